// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// APU frame counter. It runs on the CPU clock and produces the quarter-frame
// (envelope / linear counter) and half-frame (length / sweep) strobes for the
// sound channels, and raises the sticky frame IRQ. A CPU write to $4017
// selects 4-step or 5-step mode and IRQ inhibit. The sequence restarts a
// programmable number of clocks after that write. In 5-step mode the restart
// also fires an immediate quarter+half clock.
//
// Ports
//   clk           in   CPU clock (1.79 MHz)
//   reset_n       in   asynchronous active-low reset
//   reg_4017[7:0] in   $4017 write data: [7] = 5-step mode, [6] = IRQ inhibit
//   reg_event     in   one-cycle strobe, $4017 written this cycle
//   irq_ack       in   one-cycle strobe, $4015 read clears the frame IRQ
//   enable_240hz  out  quarter-frame strobe, one clk wide
//   enable_120hz  out  half-frame strobe, one clk wide
//   frame_irq     out  sticky frame interrupt flag
//   mode_5step    out  current sequencer mode (registered)
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int unsigned Q1           = 7456,
    parameter int unsigned Q2           = 14912,
    parameter int unsigned Q3           = 22370,
    parameter int unsigned Q4_4STEP     = 29828,
    parameter int unsigned Q4_5STEP     = 37280,
    parameter int unsigned PERIOD_4STEP = 29830,
    parameter int unsigned PERIOD_5STEP = 37282,
    parameter int unsigned WRITE_DELAY  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] reg_4017,
    input  logic       reg_event,
    input  logic       irq_ack,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq,
    output logic       mode_5step
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DLY_W = 3;

    localparam logic [CNT_W-1:0] Q1_C      = CNT_W'(Q1);
    localparam logic [CNT_W-1:0] Q2_C      = CNT_W'(Q2);
    localparam logic [CNT_W-1:0] Q3_C      = CNT_W'(Q3);
    localparam logic [CNT_W-1:0] Q4_4_C    = CNT_W'(Q4_4STEP);
    localparam logic [CNT_W-1:0] Q4_5_C    = CNT_W'(Q4_5STEP);
    localparam logic [CNT_W-1:0] LAST_4_C  = CNT_W'(PERIOD_4STEP - 1);
    localparam logic [CNT_W-1:0] LAST_5_C  = CNT_W'(PERIOD_5STEP - 1);
    localparam logic [DLY_W-1:0] DELAY_C   = DLY_W'(WRITE_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE_C = DLY_W'(1);

    typedef enum logic {
        ST_RUN,
        ST_PENDING
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             mode_q, mode_d;
    logic             inhibit_q, inhibit_d;
    logic             irq_q, irq_d;
    logic             qtr_q, qtr_d;
    logic             half_q, half_d;

    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] q4_cnt;
    logic             irq_set;
    logic             irq_clr_wr;

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        mode_d    = mode_q;
        inhibit_d = inhibit_q;
        irq_d     = irq_q;

        // Wrap on >= so that a switch to the shorter 4-step period while the
        // count is already past its end still brings the count back to 0.
        last_cnt = mode_q ? LAST_5_C : LAST_4_C;
        q4_cnt   = mode_q ? Q4_5_C : Q4_4_C;
        cnt_d    = (cnt_q >= last_cnt) ? '0 : cnt_q + 1'b1;

        qtr_d  = (cnt_q == Q1_C) || (cnt_q == Q2_C) ||
                 (cnt_q == Q3_C) || (cnt_q == q4_cnt);
        half_d = (cnt_q == Q2_C) || (cnt_q == q4_cnt);

        case (state_q)
            ST_RUN: begin
                if (reg_event) begin
                    dly_d   = DELAY_C;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // A write landing on the restart edge wins: the countdown
                // reloads and the restart is deferred to that write.
                if (reg_event) begin
                    dly_d = DELAY_C;
                end else if (dly_q == DLY_ONE_C) begin
                    dly_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    // Immediate clock on restart in 5-step mode, ORed with
                    // whatever the normal compare produced this edge.
                    if (mode_q) begin
                        qtr_d  = 1'b1;
                        half_d = 1'b1;
                    end
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                dly_d   = '0;
            end
        endcase

        if (reg_event) begin
            mode_d    = reg_4017[7];
            inhibit_d = reg_4017[6];
        end

        // Priority: inhibiting write clears > frame-end set > acknowledge.
        irq_set    = (cnt_q == Q4_4_C) && !mode_q && !inhibit_q;
        irq_clr_wr = reg_event && reg_4017[6];
        if (irq_clr_wr) begin
            irq_d = 1'b0;
        end else if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            dly_q     <= '0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            qtr_q     <= 1'b0;
            half_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
            qtr_q     <= qtr_d;
            half_q    <= half_d;
        end
    end

    assign enable_240hz = qtr_q;
    assign enable_120hz = half_q;
    assign frame_irq    = irq_q;
    assign mode_5step   = mode_q;

endmodule
